// File: rtl/centronix_pkg.sv
// centronix_pkg: shared state encoding, default timing and counter sizing for the Centronics transmitter
package centronix_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT_READY} tx_state_t;
  localparam int DEF_SETUP_CYC   = 4;
  localparam int DEF_STROBE_CYC  = 8;
  localparam int DEF_HOLD_CYC    = 4;
  localparam int DEF_TIMEOUT_CYC = 65535;
  localparam int DEF_FIFO_DEPTH  = 4;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/centronix_fifo.sv
// centronix_fifo: synchronous byte FIFO with count-based full/empty and sticky overflow
module centronix_fifo
  import centronix_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic       clr,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr_ok, rd_ok;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      wp       <= wr_ok ? wp + 1'b1 : wp;
      rp       <= rd_ok ? rp + 1'b1 : rp;
      cnt      <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      overflow <= clr ? 1'b0 : overflow | (wr_en & full);
    end
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= wr_data;
endmodule

// File: rtl/centronix_tx.sv
// centronix_tx: Centronics printer-port transmitter with byte FIFO, programmable strobe/busy polarity
// and a sticky timeout while waiting for the receiver to release busy.
module centronix_tx
  import centronix_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  input  logic       cfg_inv_strobe,
  input  logic       cfg_inv_busy,
  input  logic       clr_status,
  output logic [7:0] centronix,
  output logic       strobe,
  input  logic       busy,
  output logic       timeout,
  output logic       idle
);
  localparam int CW = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  tx_state_t     state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] to_cnt;
  logic          busy_m, busy_s, busy_act, inv_s_q, inv_b_q, pop;
  logic [7:0]    head;
  centronix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .rd_en(pop),
    .clr(clr_status), .rd_data(head), .full(full), .empty(empty), .overflow(overflow)
  );
  // Polarity is live while idle so the idle level tracks config; frozen during a transfer
  assign busy_act = busy_s ^ (state == IDLE ? cfg_inv_busy : inv_b_q);
  assign pop      = state == IDLE && !empty && !busy_act;
  assign strobe   = state == IDLE ? ~cfg_inv_strobe : (state == STROBE) ^ ~inv_s_q;
  assign idle     = state == IDLE && empty;
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: if (pop) begin
        nxt     = SETUP;
        cnt_nxt = CW'(SETUP_CYC - 1);
      end
      SETUP: if (cnt == '0) begin
        nxt     = STROBE;
        cnt_nxt = CW'(STROBE_CYC - 1);
      end else cnt_nxt = cnt - 1'b1;
      STROBE: if (cnt == '0) begin
        nxt     = HOLD;
        cnt_nxt = CW'(HOLD_CYC - 1);
      end else cnt_nxt = cnt - 1'b1;
      HOLD: if (cnt == '0) nxt = WAIT_READY;
      else cnt_nxt = cnt - 1'b1;
      WAIT_READY: if (!busy_act) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_m    <= 1'b0;
      busy_s    <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      to_cnt    <= '0;
      timeout   <= 1'b0;
      centronix <= '0;
      inv_s_q   <= 1'b0;
      inv_b_q   <= 1'b0;
    end else begin
      busy_m    <= busy;
      busy_s    <= busy_m;
      state     <= nxt;
      cnt       <= cnt_nxt;
      to_cnt    <= state != WAIT_READY ? '0 :
                   busy_act && to_cnt != TW'(TIMEOUT_CYC) ? to_cnt + 1'b1 : to_cnt;
      // Fires only on the step into saturation, so a clear while still waiting sticks
      timeout   <= clr_status ? 1'b0 :
                   timeout | (state == WAIT_READY && busy_act && to_cnt == TW'(TIMEOUT_CYC - 1));
      centronix <= pop ? head : centronix;
      inv_s_q   <= pop ? cfg_inv_strobe : inv_s_q;
      inv_b_q   <= pop ? cfg_inv_busy : inv_b_q;
    end
endmodule

// File: tb/tb_centronix_tx.sv
// tb_centronix_tx: directed and randomized checks of centronix_tx against a behavioural printer model
module tb_centronix_tx;
  logic       clk = 0, rst = 1;
  logic [7:0] wr_data = 0;
  logic       wr_en = 0, cfg_inv_strobe = 0, cfg_inv_busy = 0, clr_status = 0;
  logic       full, empty, overflow, strobe, timeout, idle, busy;
  logic [7:0] centronix;
  logic       man = 0, busy_man = 0, rx_rand = 0, prev_act = 0;
  int         bcnt = 0, tests = 0, fails = 0;
  logic [7:0] rxq[$], expq[$];

  centronix_tx #(.TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full), .empty(empty),
    .overflow(overflow), .cfg_inv_strobe(cfg_inv_strobe), .cfg_inv_busy(cfg_inv_busy),
    .clr_status(clr_status), .centronix(centronix), .strobe(strobe), .busy(busy),
    .timeout(timeout), .idle(idle)
  );

  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Printer model: latches data on the strobe trailing edge, then optionally stays busy a while
  assign busy = man ? busy_man : ((bcnt != 0) ^ cfg_inv_busy);
  always @(negedge clk) begin
    logic act;
    act = strobe ^ ~cfg_inv_strobe;
    if (bcnt != 0) bcnt = bcnt - 1;
    if (prev_act && !act) begin
      rxq.push_back(centronix);
      bcnt = rx_rand ? int'($urandom_range(0, 20)) : 0;
    end
    prev_act = act;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1;
    @(negedge clk);
    wr_en   = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (!idle && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", idle, 1);
  endtask

  task automatic set_cfg(input logic s, input logic b);
    #2;
    cfg_inv_strobe = s;
    cfg_inv_busy   = b;
    @(negedge clk);
  endtask

  task automatic strobe_width(input logic idle_lvl, input string tag);
    int act = 0;
    tick(3);
    check({tag, "_pre"}, strobe, idle_lvl);
    repeat (9) begin
      tick(1);
      act += (strobe != idle_lvl);
    end
    check({tag, "_width"}, act, 8);
    check({tag, "_post"}, strobe, idle_lvl);
  endtask

  initial begin
    tick(3);
    check("rst_cen", centronix, 0);
    check("rst_strobe", strobe, 1);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_ovf", overflow, 0);
    check("rst_to", timeout, 0);
    check("rst_idle", idle, 1);
    rst = 0;
    tick(2);

    // Single byte, default polarity: exact cycle timing
    wr(8'h5A);
    check("t1_empty", empty, 0);
    tick(1);
    check("t1_cen", centronix, 8'h5A);
    strobe_width(1'b1, "t1");
    tick(3);
    check("t1_idle17", idle, 0);
    tick(2);
    check("t1_idle19", idle, 1);

    // Six back-to-back writes: the FIFO absorbs one pop, so only the sixth overflows
    rxq.delete();
    for (int i = 1; i <= 6; i++) wr(8'(i * 8'h11));
    check("ovf_flag", overflow, 1);
    check("ovf_full", full, 1);
    wait_idle(300);
    check("ovf_cnt", rxq.size(), 5);
    for (int i = 0; i < 5 && i < rxq.size(); i++) check("ovf_byte", rxq[i], 8'((i + 1) * 8'h11));
    clr_status = 1;
    tick(1);
    clr_status = 0;
    check("ovf_clr", overflow, 0);

    // Receiver holds busy 100 cycles after strobe release; next pop waits out the synchronizer
    man = 1;
    busy_man = 0;
    wr(8'hA1);
    wr(8'hB2);
    begin
      int n = 0;
      while (strobe && n < 30) begin tick(1); n++; end
      while (!strobe && n < 30) begin tick(1); n++; end
      check("bsy_strobe_seen", n < 30, 1);
    end
    busy_man = 1;
    tick(100);
    check("bsy_hold_cen", centronix, 8'hA1);
    check("bsy_hold_idle", idle, 0);
    busy_man = 0;
    tick(3);
    check("bsy_rel3", centronix, 8'hA1);
    tick(1);
    check("bsy_rel4", centronix, 8'hB2);
    wait_idle(40);
    clr_status = 1;
    tick(1);
    clr_status = 0;

    // Inverted strobe and busy
    busy_man = 1;
    set_cfg(1, 1);
    check("inv_idle_strobe", strobe, 0);
    wr(8'hC3);
    wr(8'hD4);
    strobe_width(1'b0, "inv");
    busy_man = 0;
    tick(30);
    check("inv_busy_cen", centronix, 8'hC3);
    check("inv_busy_idle", idle, 0);
    busy_man = 1;
    wait_idle(40);
    check("inv_second", centronix, 8'hD4);
    busy_man = 0;
    set_cfg(0, 0);

    // Timeout while busy stays asserted
    wr(8'h3C);
    tick(13);
    busy_man = 1;
    tick(53);
    check("to_67", timeout, 0);
    tick(1);
    check("to_68", timeout, 1);
    tick(5);
    check("to_wait_idle", idle, 0);
    check("to_wait_strobe", strobe, 1);
    clr_status = 1;
    tick(1);
    clr_status = 0;
    check("to_clr", timeout, 0);
    tick(3);
    check("to_clr_stick", timeout, 0);
    busy_man = 0;
    wait_idle(10);
    man = 0;

    // Async reset mid-strobe
    wr(8'hE5);
    wr(8'hF6);
    tick(6);
    check("rst_mid_strobe", strobe, 0);
    #2 rst = 1;
    #1 check("rst_async_strobe", strobe, 1);
    @(posedge clk);
    #1;
    check("rst_mid_empty", empty, 1);
    check("rst_mid_cen", centronix, 0);
    @(negedge clk);
    rst = 0;
    tick(2);

    // Randomized bursts against the printer model
    rxq.delete();
    expq.delete();
    rx_rand = 1;
    repeat (10) begin
      int n;
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 4);
      repeat (n) begin
        logic [7:0] b;
        b = 8'($urandom);
        expq.push_back(b);
        wr(b);
        tick($urandom_range(0, 30));
      end
      wait_idle(400);
    end
    check("rnd_cnt", rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) check("rnd_byte", rxq[i], expq[i]);
    check("rnd_ovf", overflow, 0);
    check("rnd_to", timeout, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
